// File: rtl/cache_mem_responder_if.sv
// Line-fill / writeback bus between the cache controller (master) and the
// memory responder (slave).
interface cache_mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BITS  = 128
) ();
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_BITS-1:0]  mem_wdata;
  logic [LINE_BITS-1:0]  mem_rdata;
  logic                  ca_resp;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, ca_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, ca_resp
  );
endinterface

// File: rtl/cache_mem_responder.sv
// Main-memory responder for whole-line reads and writebacks, with a fixed
// response latency and an internal line-wide storage array.
module cache_mem_responder #(
  parameter int ADDR_WIDTH       = 32,
  parameter int LINE_BITS        = 128,
  parameter int DEPTH_LINES      = 256,
  parameter int LATENCY          = 3,
  parameter int READ_RESP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_mem_responder_if.slave bus,
  output logic                 busy,
  output logic                 error,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count
);

  localparam int OFF   = $clog2(LINE_BITS / 8);
  localparam int IDX   = $clog2(DEPTH_LINES);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int RSP_W = (READ_RESP_CYCLES > 1) ? $clog2(READ_RESP_CYCLES) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);
  localparam logic [RSP_W-1:0] RD_LOAD  = RSP_W'(READ_RESP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, RECOVER} state_t;

  state_t               state, state_nxt;
  logic [LAT_W-1:0]     lat_cnt, lat_nxt;
  logic [RSP_W-1:0]     rsp_cnt, rsp_nxt;
  logic                 op_wr_p0, op_wr_nxt;
  logic [IDX-1:0]       idx_p0;
  logic [LINE_BITS-1:0] wdata_p0;
  logic                 ca_resp_nxt;
  logic                 error_nxt;
  logic [15:0]          rd_nxt, wr_nxt;
  logic                 accept;
  logic                 rdata_ld;
  logic                 st_we;
  logic                 req_held;
  logic                 unused_addr;

  logic [LINE_BITS-1:0] storage [DEPTH_LINES];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Upper and offset address bits alias onto the same line.
  assign unused_addr = ^bus.mem_addr;

  assign req_held = op_wr_p0 ? bus.mem_write : bus.mem_read;

  always_comb begin
    state_nxt   = state;
    lat_nxt     = lat_cnt;
    rsp_nxt     = rsp_cnt;
    op_wr_nxt   = op_wr_p0;
    ca_resp_nxt = 1'b0;
    error_nxt   = 1'b0;
    rd_nxt      = rd_count;
    wr_nxt      = wr_count;
    accept      = 1'b0;
    rdata_ld    = 1'b0;
    st_we       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_write || bus.mem_read) begin
          // Write wins a simultaneous request; the conflict is flagged.
          accept    = 1'b1;
          op_wr_nxt = bus.mem_write;
          lat_nxt   = LAT_LOAD;
          error_nxt = bus.mem_write && bus.mem_read;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!req_held) begin
          state_nxt = IDLE;
          error_nxt = 1'b1;
          lat_nxt   = '0;
        end else if (lat_cnt == '0) begin
          state_nxt   = RESP;
          ca_resp_nxt = 1'b1;
          if (op_wr_p0) begin
            st_we   = 1'b1;
            wr_nxt  = sat_inc(wr_count);
            rsp_nxt = '0;
          end else begin
            rdata_ld = 1'b1;
            rd_nxt   = sat_inc(rd_count);
            rsp_nxt  = RD_LOAD;
          end
        end else begin
          lat_nxt = lat_cnt - LAT_W'(1);
        end
      end
      RESP: begin
        if (rsp_cnt == '0) begin
          state_nxt = RECOVER;
        end else begin
          rsp_nxt     = rsp_cnt - RSP_W'(1);
          ca_resp_nxt = 1'b1;
        end
      end
      RECOVER: begin
        // Swallows the requester's still-asserted request from the last RESP cycle.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- control / output register stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      rsp_cnt       <= '0;
      op_wr_p0      <= 1'b0;
      bus.ca_resp   <= 1'b0;
      bus.mem_rdata <= '0;
      busy          <= 1'b0;
      error         <= 1'b0;
      rd_count      <= '0;
      wr_count      <= '0;
    end else begin
      state       <= state_nxt;
      lat_cnt     <= lat_nxt;
      rsp_cnt     <= rsp_nxt;
      op_wr_p0    <= op_wr_nxt;
      bus.ca_resp <= ca_resp_nxt;
      busy        <= (state_nxt != IDLE);
      error       <= error_nxt;
      rd_count    <= rd_nxt;
      wr_count    <= wr_nxt;
      if (rdata_ld) begin
        bus.mem_rdata <= storage[idx_p0];
      end
    end
  end

  // ---- request capture stage ----
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_p0   <= bus.mem_addr[OFF+IDX-1:OFF];
      wdata_p0 <= bus.mem_wdata;
    end
  end

  // ---- storage commit at RESP entry ----
  always_ff @(posedge clk) begin
    if (st_we) begin
      storage[idx_p0] <= wdata_p0;
    end
  end

endmodule
